// File: rtl/resonator_ddc_sdiv_34s_16s_18s_seq.sv
// Sequential signed divider, 34s / 16s -> 18s quotient plus 16s remainder.
// Radix-2 restoring divide on operand magnitudes, one quotient bit per enabled
// cycle. The quotient saturates on overflow and on a zero divisor.
//
// state | meaning
// IDLE  | ready for operands, din_ready=1
// CALC  | 34 shift/subtract iterations, cnt counts down 33..0
// FIX   | apply signs, saturate, register the result
// DONE  | result held on dout until the downstream accepts it
module resonator_ddc_sdiv_34s_16s_18s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 34,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] dout_rem,
    output logic                  dout_ovf
);

    // The datapath below is written for the fixed 34/16/18 geometry only.
    if (din0_WIDTH != 34 || din1_WIDTH != 16 || dout_WIDTH != 18 || ID < 0) begin : g_bad_cfg
        $error("resonator_ddc_sdiv_34s_16s_18s_seq: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sign_a;
    logic        sign_b;
    logic [33:0] dvd;      // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [15:0] dvs;
    logic [16:0] rem;      // partial remainder, always < |divisor| <= 32768 between steps
    logic [5:0]  cnt;

    logic        in_xfer;
    logic        out_xfer;
    logic [17:0] diff;
    logic        q_bit;
    logic        neg;
    logic        pos_ovf;
    logic        neg_ovf;
    logic [33:0] a_mag;
    logic [15:0] b_mag;

    assign din_ready = (state == IDLE);
    assign in_xfer   = ce & din_valid & din_ready;
    assign out_xfer  = ce & dout_valid & dout_ready;

    assign a_mag = din0[33] ? 34'(-din0) : din0;
    assign b_mag = din1[15] ? 16'(-din1) : din1;

    // Shifted remainder minus divisor; bit 17 is the borrow, so no borrow means the quotient bit is 1.
    assign diff  = {rem, dvd[33]} - {2'b00, dvs};
    assign q_bit = ~diff[17];

    // A zero quotient carries no sign; -131072 is the one negative magnitude beyond +131071 that fits.
    assign neg     = (sign_a ^ sign_b) & (|dvd);
    assign pos_ovf = ~neg & (dvd > 34'd131071);
    assign neg_ovf =  neg & (dvd > 34'd131072);

    // State register; reset wins over ce, ce=0 freezes the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (din_valid)  state_nxt = CALC;
            CALC: if (cnt == 6'd0) state_nxt = FIX;
            FIX:                  state_nxt = DONE;
            DONE: if (dout_ready) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Operand capture, iterative divide, result formatting and output hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            cnt        <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_rem   <= '0;
            dout_ovf   <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        sign_a <= din0[33];
                        sign_b <= din1[15];
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        rem    <= '0;
                        cnt    <= 6'd33;
                    end
                end
                CALC: begin
                    rem <= q_bit ? diff[16:0] : {rem[15:0], dvd[33]};
                    dvd <= {dvd[32:0], q_bit};
                    cnt <= cnt - 6'd1;
                end
                FIX: begin
                    dout_valid <= 1'b1;
                    if (dvs == 16'd0) begin
                        dout     <= sign_a ? 18'h20000 : 18'h1FFFF;
                        dout_rem <= '0;
                        dout_ovf <= 1'b1;
                    end else if (pos_ovf) begin
                        dout     <= 18'h1FFFF;
                        dout_rem <= '0;
                        dout_ovf <= 1'b1;
                    end else if (neg_ovf) begin
                        dout     <= 18'h20000;
                        dout_rem <= '0;
                        dout_ovf <= 1'b1;
                    end else begin
                        dout     <= neg ? 18'(-dvd[17:0]) : dvd[17:0];
                        dout_rem <= sign_a ? 16'(-rem[15:0]) : rem[15:0];
                        dout_ovf <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_xfer) dout_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
